// File: rtl/seq_timing_gen.sv
// seq_timing_gen: sequence counter with a registered one-hot timing decode.
// Drives the T0..Tn phase strobes for the control unit.
// Adds a programmable wrap point, clear, load, a wrap pulse and a load-error pulse.
// T is registered from the next-state count, so it never lags SC by a cycle.
module seq_timing_gen #(
  parameter int SC_WIDTH  = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     INC,
  input  logic                     LD,
  input  logic [SC_WIDTH-1:0]      LD_VAL,
  output logic [SC_WIDTH-1:0]      SC,
  output logic [2**SC_WIDTH-1:0]   T,
  output logic                     WRAP,
  output logic                     LD_ERR
);

  localparam int T_W = 2**SC_WIDTH;

  // Reject a wrap point that the counter cannot represent.
  generate
    if (MAX_COUNT < 1 || MAX_COUNT > T_W - 1) begin : g_bad_max
      $error("seq_timing_gen: MAX_COUNT out of range 1..2**SC_WIDTH-1");
    end
  endgenerate

  logic [SC_WIDTH-1:0] sc_nxt;
  logic [T_W-1:0]      t_nxt;
  logic                wrap_nxt;
  logic                err_nxt;
  logic                ld_ok;
  logic                at_max;

  // Compare in 32-bit space so a full-range MAX_COUNT does not collapse to a
  // constant-true compare at SC_WIDTH bits.
  assign ld_ok  = (int'(LD_VAL) <= MAX_COUNT);
  // ">=" also recovers an out-of-range SC on the next INC.
  assign at_max = (int'(SC) >= MAX_COUNT);

  // Next-state selection, priority CLR > LD > INC > hold.
  always_comb begin
    sc_nxt   = SC;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (CLR) begin
      sc_nxt = '0;
    end else if (LD) begin
      if (ld_ok) sc_nxt  = LD_VAL;
      else       err_nxt = 1'b1;
    end else if (INC) begin
      if (at_max) begin
        sc_nxt   = '0;
        wrap_nxt = 1'b1;
      end else begin
        sc_nxt = SC + 1'b1;
      end
    end
  end

  // One-hot decode of the next count; steps past the wrap point are tied off.
  genvar k;
  generate
    for (k = 0; k < T_W; k++) begin : g_dec
      if (k <= MAX_COUNT) begin : g_live
        assign t_nxt[k] = (sc_nxt == SC_WIDTH'(k));
      end else begin : g_dead
        assign t_nxt[k] = 1'b0;
      end
    end
  endgenerate

  // State and output registers; reset parks the sequence on T0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SC     <= '0;
      T      <= T_W'(1);
      WRAP   <= 1'b0;
      LD_ERR <= 1'b0;
    end else begin
      SC     <= sc_nxt;
      T      <= t_nxt;
      WRAP   <= wrap_nxt;
      LD_ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seq_timing_gen.sv
// Directed bench for seq_timing_gen: a default instance (MAX_COUNT=15) and a
// short-wrap instance (MAX_COUNT=7) share clock and reset.
module tb_seq_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  // default instance
  logic        clr, inc, ld;
  logic [3:0]  ld_val;
  logic [3:0]  sc;
  logic [15:0] t;
  logic        wrap, ld_err;
  // short-wrap instance
  logic        clr7, inc7, ld7;
  logic [3:0]  ld_val7;
  logic [3:0]  sc7;
  logic [15:0] t7;
  logic        wrap7, ld_err7;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_timing_gen #(.SC_WIDTH(4), .MAX_COUNT(15)) dut (
    .CLK(clk), .RST(rst), .CLR(clr), .INC(inc), .LD(ld), .LD_VAL(ld_val),
    .SC(sc), .T(t), .WRAP(wrap), .LD_ERR(ld_err)
  );

  seq_timing_gen #(.SC_WIDTH(4), .MAX_COUNT(7)) dut7 (
    .CLK(clk), .RST(rst), .CLR(clr7), .INC(inc7), .LD(ld7), .LD_VAL(ld_val7),
    .SC(sc7), .T(t7), .WRAP(wrap7), .LD_ERR(ld_err7)
  );

  // T must be exactly one-hot and track SC on both instances.
  always @(negedge clk) begin
    if (!rst) begin
      assert ($countones(t) == 1 && t == (16'd1 << sc));
      assert ($countones(t7) == 1 && t7 == (16'd1 << sc7) && t7[15:8] == 8'h00);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk15(input string tag, input int esc, input bit ew, input bit ee);
    chk({tag, ".sc"},   32'(sc),     32'(esc));
    chk({tag, ".t"},    32'(t),      32'd1 << esc);
    chk({tag, ".wrap"}, 32'(wrap),   32'(ew));
    chk({tag, ".err"},  32'(ld_err), 32'(ee));
  endtask

  task automatic chk7(input string tag, input int esc, input bit ew, input bit ee);
    chk({tag, ".sc"},   32'(sc7),     32'(esc));
    chk({tag, ".t"},    32'(t7),      32'd1 << esc);
    chk({tag, ".wrap"}, 32'(wrap7),   32'(ew));
    chk({tag, ".err"},  32'(ld_err7), 32'(ee));
  endtask

  initial begin
    int m, e_sc;
    bit mw, me, r_clr, r_ld, r_inc;
    logic [3:0] r_val;

    rst = 1'b1;
    clr = 0; inc = 0; ld = 0; ld_val = 0;
    clr7 = 0; inc7 = 0; ld7 = 0; ld_val7 = 0;
    step(); step();
    chk15("rst", 0, 0, 0);
    chk7("rst7", 0, 0, 0);
    #2 rst = 1'b0;

    // free count from reset: 1..15, 0 (wrap), 1
    inc = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      e_sc = i % 16;
      chk15($sformatf("free%0d", i), e_sc, (i == 16), 0);
    end
    inc = 0;

    // async reset mid-count at SC=5, no clock edge involved
    ld = 1; ld_val = 4'd5;
    step();
    ld = 0;
    chk15("ld5", 5, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk15("async_rst", 0, 0, 0);
    #2 rst = 1'b0;

    // priority: CLR beats LD and INC at SC=3, then LD beats INC
    ld = 1; ld_val = 4'd3;
    step();
    chk15("ld3", 3, 0, 0);
    clr = 1; ld = 1; ld_val = 4'd9; inc = 1;
    step();
    chk15("clr_pri", 0, 0, 0);
    clr = 0;
    step();
    chk15("ld_pri", 9, 0, 0);
    ld = 0; inc = 0;
    step();
    chk15("hold", 9, 0, 0);

    // wrap pulse lasts one cycle; CLR after a wrap drops it
    ld = 1; ld_val = 4'd15;
    step();
    ld = 0; inc = 1;
    step();
    chk15("wrap15", 0, 1, 0);
    inc = 0; clr = 1;
    step();
    chk15("clr_wrap", 0, 0, 0);
    clr = 0;

    // short wrap point: SC cycles 0..7, WRAP every 8th edge
    inc7 = 1;
    for (int i = 1; i <= 24; i++) begin
      step();
      e_sc = i % 8;
      chk7($sformatf("short%0d", i), e_sc, (i % 8 == 0), 0);
    end
    inc7 = 0;

    // illegal load at SC=2 holds state and pulses LD_ERR once
    ld7 = 1; ld_val7 = 4'd2;
    step();
    chk7("ld2", 2, 0, 0);
    ld_val7 = 4'd12; inc7 = 1;
    step();
    chk7("ld_bad", 2, 0, 1);
    ld7 = 0; inc7 = 0;
    step();
    chk7("ld_bad_after", 2, 0, 0);

    // load boundary: 7 accepted, 8 rejected
    ld7 = 1; ld_val7 = 4'd7;
    step();
    chk7("ld7", 7, 0, 0);
    ld_val7 = 4'd8;
    step();
    chk7("ld8", 7, 0, 1);
    step();
    chk7("ld8_again", 7, 0, 1);
    ld7 = 0;
    step();
    chk7("ld8_clear", 7, 0, 0);

    // random CLR/LD/INC against a behavioural reference
    clr7 = 1;
    step();
    clr7 = 0;
    m = 0;
    for (int i = 0; i < 1000; i++) begin
      r_clr = ($urandom_range(0, 15) == 0);
      r_ld  = ($urandom_range(0, 3) == 0);
      r_inc = ($urandom_range(0, 1) == 1);
      r_val = 4'($urandom_range(0, 15));
      clr7 = r_clr; ld7 = r_ld; inc7 = r_inc; ld_val7 = r_val;
      mw = 0; me = 0;
      if (r_clr) m = 0;
      else if (r_ld) begin
        if (r_val <= 7) m = r_val;
        else me = 1;
      end else if (r_inc) begin
        if (m == 7) begin m = 0; mw = 1; end
        else m = m + 1;
      end
      step();
      chk7($sformatf("rnd%0d", i), m, mw, me);
      chk($sformatf("rnd%0d.ones", i), 32'($countones(t7)), 32'd1);
    end
    clr7 = 0; ld7 = 0; inc7 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_timing_gen.md
Name: seq_timing_gen

Overview:
- Parametrised sequence counter with a registered one-hot timing decode. It generalises the fixed 4-to-16 decode into a stateful timing generator.
- Produces the T0..Tn timing signals that the control unit uses to step instruction phases.
- Adds a programmable wrap point, clear, load and a wrap pulse that a plain decoder cannot provide.
- Sits between the control logic (which drives CLR/INC/LD) and every block that gates on a timing step.

Parameters:
- SC_WIDTH, 4, width of the sequence counter; T is 2**SC_WIDTH bits wide.
- MAX_COUNT, 15, last count before wrap. Legal range is 1..2**SC_WIDTH-1; an illegal value is an elaboration error.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- CLR  input  1  synchronous clear of the counter to 0.
- INC  input  1  advance the counter by one step.
- LD  input  1  synchronous load of LD_VAL.
- LD_VAL  input  SC_WIDTH  load value.
- SC  output  SC_WIDTH  current count, registered.
- T  output  2**SC_WIDTH  one-hot timing vector, registered; T[k]=1 iff SC==k.
- WRAP  output  1  one-cycle pulse, registered; high in the cycle after an INC-driven wrap.
- LD_ERR  output  1  one-cycle pulse, registered; high in the cycle after a rejected load.

Behaviour:
- Reset (RST=1, asynchronous, takes effect without waiting for CLK):
  - SC=0, T=1 (T0 asserted), WRAP=0, LD_ERR=0.
  - Reset overrides everything, including a reset asserted mid-sequence.
- On release of RST, the first rising edge evaluates inputs normally.
- Per-edge priority is CLR > LD > INC > hold.
- CLR=1: SC←0, T←onehot(0), WRAP←0, LD_ERR←0. Any simultaneous LD or INC is ignored.
- LD=1 (CLR=0):
  - If LD_VAL ≤ MAX_COUNT: SC←LD_VAL, T←onehot(LD_VAL), LD_ERR←0.
  - If LD_VAL > MAX_COUNT: SC and T hold, LD_ERR←1.
  - WRAP←0 in both cases. INC is ignored in the same cycle.
- INC=1 (CLR=0, LD=0):
  - If SC < MAX_COUNT: SC←SC+1, WRAP←0.
  - If SC == MAX_COUNT: SC←0, WRAP←1.
  - T follows SC on the same edge.
- All inputs low: SC and T hold, WRAP←0, LD_ERR←0.
- T invariants:
  - T is always exactly one-hot and always equals onehot(SC). There is no cycle of skew, because T is registered from the next-state value, not decoded from SC.
  - Bits T[k] for k > MAX_COUNT never assert.
- Latency: an input change is visible on SC/T/WRAP/LD_ERR one edge later. No combinational path exists from inputs to outputs.
- Arithmetic: the increment is done modulo MAX_COUNT+1, not modulo 2**SC_WIDTH. No intermediate value ever exceeds MAX_COUNT.
- WRAP and LD_ERR are never held high for two consecutive cycles unless the triggering event repeats.
- No undefined states exist. If SC is ever above MAX_COUNT (not reachable by design), the next INC forces SC←0 with WRAP←1.

Test Plan:
- Reset check: RST pulsed asynchronously mid-count at SC=5, no clock edge → SC=0, T=16'h0001, WRAP=0 immediately.
- Free count, defaults: INC=1 held for 17 edges from reset → SC runs 1..15, then 0, then 1. WRAP=1 only in the cycle where SC=0. T=16'h8000 when SC=15.
- Short wrap point: MAX_COUNT=7, SC_WIDTH=4, INC held → SC cycles 0..7. T never exceeds 16'h0080. WRAP pulses every 8th edge.
- Priority: CLR=1, LD=1, LD_VAL=9 and INC=1 on the same edge at SC=3 → SC=0, T=1. Next edge LD=1, INC=1, LD_VAL=9 → SC=9, T=16'h0200.
- Illegal load: MAX_COUNT=7, SC=2, LD=1, LD_VAL=12 → SC stays 2, T=16'h0004, LD_ERR=1 for exactly one cycle.
- Hold and one-hot: random CLR/LD/INC for 1000 cycles → T==onehot(SC) and $countones(T)==1 every cycle, checked with an assertion.
